// File: rtl/alu_ops_pkg.sv
// Opcodes, FSM states and datapath sizes shared by the ALU controller and the
// multiply/divide unit.
package alu_ops_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [4:0] NOP   = 5'd0;
    localparam logic [4:0] AND   = 5'd1;
    localparam logic [4:0] OR    = 5'd2;
    localparam logic [4:0] XOR   = 5'd3;
    localparam logic [4:0] NOR   = 5'd4;
    localparam logic [4:0] SLL   = 5'd5;
    localparam logic [4:0] SRL   = 5'd6;
    localparam logic [4:0] SRA   = 5'd7;
    localparam logic [4:0] ADD   = 5'd8;
    localparam logic [4:0] SUB   = 5'd9;
    localparam logic [4:0] ADDU  = 5'd10;
    localparam logic [4:0] SUBU  = 5'd11;
    localparam logic [4:0] MULT  = 5'd12;
    localparam logic [4:0] DIV   = 5'd13;
    localparam logic [4:0] SLT_U = 5'd14;
    localparam logic [4:0] SLT_S = 5'd15;

    typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide
// unit (slave).
interface mult_div_unit_if #(
    parameter int WIDTH = alu_ops_pkg::WIDTH
);
    logic             start;
    logic             flush;
    logic [4:0]       alu_operation;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, flush, alu_operation, op_a, op_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, flush, alu_operation, op_a, op_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/md_sign_fix.sv
// Turns unsigned multiply/divide magnitudes into signed HI/LO values
// (product negation, or quotient/remainder sign restoration).
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic             res_neg,
    input  logic             dvd_neg,
    input  logic [WIDTH-1:0] mag_hi,
    input  logic [WIDTH-1:0] mag_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [2*WIDTH-1:0] prod;

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        prod = res_neg ? -{mag_hi, mag_lo} : {mag_hi, mag_lo};
        hi   = prod[2*WIDTH-1:WIDTH];
        lo   = prod[WIDTH-1:0];
        if (is_div) begin
            // Quotient truncates toward zero; remainder follows the dividend.
            lo = res_neg ? -mag_lo : mag_lo;
            hi = dvd_neg ? -mag_hi : mag_hi;
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV unit owning HI/LO. Define MULTDIV_EARLY_TERM_EN to
// let MULT finish as soon as the remaining multiplier bits are all zero.
module mult_div_unit #(
    parameter int WIDTH = alu_ops_pkg::WIDTH,
    parameter int CNT_W = alu_ops_pkg::CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave md
);
    import alu_ops_pkg::*;

    md_state_t          state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, dz_op, res_neg, dvd_neg;
    logic [WIDTH-1:0]   opnd, mplier;
    logic [2*WIDTH-1:0] acc;
    logic               busy_q, done_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, op_is_div, b_zero, skip_calc, mul_early;
    logic [WIDTH-1:0]   abs_a, abs_b, mul_mplier, fix_hi, fix_lo;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] mul_acc, mul_next, div_shift, div_next;

    assign op_is_div = (md.alu_operation == DIV);
    assign b_zero    = (md.op_b == '0);
    assign abs_a     = md.op_a[WIDTH-1] ? -md.op_a : md.op_a;
    assign abs_b     = md.op_b[WIDTH-1] ? -md.op_b : md.op_b;
    assign accept    = md.start && !md.flush && (state == IDLE) && is_md_op(md.alu_operation);
`ifdef MULTDIV_EARLY_TERM_EN
    assign skip_calc = b_zero;
`else
    assign skip_calc = op_is_div && b_zero;
`endif

    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, opnd} : '0);
        mul_acc    = {mul_sum, acc[WIDTH-1:1]};
        mul_mplier = mplier >> 1;
`ifdef MULTDIV_EARLY_TERM_EN
        // Skipped iterations would only shift, so align the accumulator in one step.
        mul_early  = (mul_mplier == '0);
        mul_next   = mul_early ? (mul_acc >> cnt) : mul_acc;
`else
        mul_early  = 1'b0;
        mul_next   = mul_acc;
`endif
        div_shift  = acc << 1;
        div_diff   = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
        div_next   = div_diff[WIDTH] ? div_shift
                                     : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:0] | WIDTH'(1)};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = skip_calc ? FIX : CALC;
            CALC: if (md.flush) state_next = IDLE;
                  else if (cnt == '0 || (!is_div && mul_early)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_div  (is_div),
        .res_neg (res_neg),
        .dvd_neg (dvd_neg),
        .mag_hi  (acc[2*WIDTH-1:WIDTH]),
        .mag_lo  (acc[WIDTH-1:0]),
        .hi      (fix_hi),
        .lo      (fix_lo)
    );

    // NOTE: the datapath is a handful of flops, not a memory, so all of it is
    // reset to keep abort-by-reset fully deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0; is_div <= 1'b0; dz_op <= 1'b0; res_neg <= 1'b0; dvd_neg <= 1'b0;
            opnd <= '0; mplier <= '0; acc <= '0;
            busy_q <= 1'b0; done_q <= 1'b0; dz_q <= 1'b0; hi_q <= '0; lo_q <= '0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_next != IDLE);
            if (accept) begin
                is_div  <= op_is_div;
                dz_op   <= op_is_div && b_zero;
                res_neg <= md.op_a[WIDTH-1] ^ md.op_b[WIDTH-1];
                dvd_neg <= md.op_a[WIDTH-1];
                opnd    <= op_is_div ? abs_b : abs_a;
                mplier  <= op_is_div ? '0 : abs_b;
                // A zero divisor parks |op_a| in the remainder half so FIX yields hi = op_a.
                acc     <= !op_is_div ? '0 : b_zero ? {abs_a, WIDTH'(0)} : {WIDTH'(0), abs_a};
                cnt     <= '1;
                dz_q    <= 1'b0;
            end else if (state == CALC && !md.flush) begin
                acc    <= is_div ? div_next : mul_next;
                mplier <= mul_mplier;
                cnt    <= cnt - CNT_W'(1);
            end else if (state == FIX && !md.flush) begin
                hi_q   <= fix_hi;
                lo_q   <= dz_op ? '1 : fix_lo;
                done_q <= 1'b1;
                dz_q   <= dz_op;
            end
        end
    end

    assign md.busy        = busy_q;
    assign md.done        = done_q;
    assign md.div_by_zero = dz_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;
endmodule
